// File: rtl/irq_pkg.sv
// Shared definitions for the request collector: channel sizing, FSM states and a
// 2->4 one-hot decoder.
package irq_pkg;

   localparam int unsigned IRQ_CH   = 4;
   localparam int unsigned IRQ_IDXW = 2;

   typedef enum logic [0:0] {
      IRQ_IDLE,
      IRQ_HOLD
   } irq_state_e;

   // Decode a channel index into a single-bit mask.
   function automatic logic [IRQ_CH-1:0] irq_onehot(input logic [IRQ_IDXW-1:0] idx);
      logic [IRQ_CH-1:0] res;
      res      = '0;
      res[idx] = 1'b1;
      return res;
   endfunction

endpackage

// File: rtl/irq_edge_det.sv
// Rising-edge detector for the raw request lines.
// Optional feature: define IRQ_SYNC_EN to insert a 2-flop synchronizer ahead of
// the edge detector (adds two cycles of latency).
module irq_edge_det
   import irq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [IRQ_CH-1:0] req,
   output logic [IRQ_CH-1:0] rise
);

   logic [IRQ_CH-1:0] req_s;
   logic [IRQ_CH-1:0] req_q;

`ifdef IRQ_SYNC_EN
   logic [IRQ_CH-1:0] sync1_q;
   logic [IRQ_CH-1:0] sync2_q;

   // Two-stage synchronizer for requests from another clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= req;
         sync2_q <= sync1_q;
      end
   end

   assign req_s = sync2_q;
`else
   assign req_s = req;
`endif

   // Previous-cycle request level; resets to 0 so a line high at release is an event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q <= '0;
      end else begin
         req_q <= req_s;
      end
   end

   assign rise = req_s & ~req_q;

endmodule

// File: rtl/irq_req_collector.sv
// Four-channel request collector feeding a 4-to-2 priority encoder. Captures
// request edges into a pending register, presents a frozen masked snapshot on
// d_out, and clears the channel the encoder selects when ack is given.
// Optional feature: IRQ_SYNC_EN (see irq_edge_det).
module irq_req_collector
   import irq_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [IRQ_CH-1:0]   req,
   input  logic [IRQ_CH-1:0]   mask,
   input  logic [IRQ_IDXW-1:0] sel,
   input  logic                ack,
   output logic [IRQ_CH-1:0]   d_out,
   output logic                vld,
   output logic [IRQ_IDXW-1:0] served,
   output logic                err
);

   irq_state_e          state_q, state_d;
   logic [IRQ_CH-1:0]   rise;
   logic [IRQ_CH-1:0]   pend_q;
   logic [IRQ_CH-1:0]   snap_q;
   logic [IRQ_CH-1:0]   elig;
   logic [IRQ_CH-1:0]   clr;
   logic [IRQ_IDXW-1:0] served_q;
   logic                err_q;
   logic                take;
   logic                hit;

   irq_edge_det u_edge_det (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .rise (rise)
   );

   assign elig = pend_q & ~mask;
   assign take = (state_q == IRQ_HOLD) && ack;
   assign hit  = snap_q[sel];

   // Clear only the acknowledged channel, and only if it was really in the snapshot.
   always_comb begin
      clr = '0;
      if (take && hit) begin
         clr = irq_onehot(sel);
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IRQ_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: present when anything unmasked is pending, release on ack.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IRQ_IDLE: if (|elig) state_d = IRQ_HOLD;
         IRQ_HOLD: if (ack)   state_d = IRQ_IDLE;
      endcase
   end

   // Output decode: snapshot is only driven while holding.
   always_comb begin
      d_out = '0;
      vld   = 1'b0;
      if (state_q == IRQ_HOLD) begin
         d_out = snap_q;
         vld   = 1'b1;
      end
   end

   // Pending events; a new edge wins over a same-cycle clear so nothing is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= (pend_q & ~clr) | rise;
      end
   end

   // Snapshot is taken on leaving IDLE and frozen for the whole HOLD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_q <= '0;
      end else if ((state_q == IRQ_IDLE) && (|elig)) begin
         snap_q <= elig;
      end
   end

   // Served index and error pulse from the acknowledge outcome.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         served_q <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= take && !hit;
         if (take && hit) begin
            served_q <= sel;
         end
      end
   end

   assign served = served_q;
   assign err    = err_q;

endmodule

// File: tb/tb_irq_req_collector.sv
// Self-checking bench for irq_req_collector: directed scenarios followed by random
// traffic, all compared against an event-level reference model.
module tb_irq_req_collector;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] mask;
   logic [1:0] sel;
   logic       ack;
   logic [3:0] d_out;
   logic       vld;
   logic [1:0] served;
   logic       err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: set of pending channels, whether a snapshot is on offer.
   bit       m_prev [4];
   bit       m_pend [4];
   bit       m_snap [4];
   bit       m_hold;
   bit       m_err;
   int       m_served;

   irq_req_collector dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .mask   (mask),
      .sel    (sel),
      .ack    (ack),
      .d_out  (d_out),
      .vld    (vld),
      .served (served),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] m_dout();
      logic [3:0] d;
      d = '0;
      if (m_hold) for (int i = 0; i < 4; i++) d[i] = m_snap[i];
      return d;
   endfunction

   // What the downstream encoder produces: index of the highest set bit.
   function automatic logic [1:0] encode(input logic [3:0] d);
      for (int i = 3; i >= 0; i--) if (d[i]) return 2'(i);
      return 2'd0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_prev[i] = 0;
         m_pend[i] = 0;
         m_snap[i] = 0;
      end
      m_hold   = 0;
      m_err    = 0;
      m_served = 0;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic [3:0] m, input bit a,
                             input int s);
      int  cleared;
      bit  any;
      bit  start;
      cleared = -1;
      start   = 0;
      m_err   = 0;
      if (m_hold) begin
         if (a) begin
            if (m_snap[s]) begin
               cleared  = s;
               m_served = s;
            end else begin
               m_err = 1;
            end
            m_hold = 0;
         end
      end else begin
         any = 0;
         for (int i = 0; i < 4; i++) if (m_pend[i] && !m[i]) any = 1;
         if (any) begin
            for (int i = 0; i < 4; i++) m_snap[i] = m_pend[i] && !m[i];
            start = 1;
         end
      end
      if (start) m_hold = 1;
      for (int i = 0; i < 4; i++) begin
         m_pend[i] = (m_pend[i] && (i != cleared)) || (r[i] && !m_prev[i]);
         m_prev[i] = r[i];
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "_vld"},    8'(vld),    8'(m_hold));
      check_eq({tag, "_dout"},   8'(d_out),  8'(m_dout()));
      check_eq({tag, "_served"}, 8'(served), 8'(m_served));
      check_eq({tag, "_err"},    8'(err),    8'(m_err));
   endtask

   // One clock: drive inputs (sel from the encoder, or a deliberately wrong index),
   // step model on the edge, check on the falling edge.
   task automatic cycle(input logic [3:0] r, input logic [3:0] m, input bit a, input bit bad,
                        input string tag);
      logic [1:0] s;
      s = encode(m_dout());
      if (bad && m_hold) begin
         for (int i = 3; i >= 0; i--) if (!m_snap[i]) s = 2'(i);
      end
      req  = r;
      mask = m;
      sel  = s;
      ack  = a;
      @(posedge clk);
      model_edge(r, m, a, int'(s));
      @(negedge clk);
      check_outputs(tag);
   endtask

   initial begin
      logic [3:0] r;
      logic [3:0] m;
      rst  = 1'b1;
      req  = '0;
      mask = '0;
      sel  = '0;
      ack  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs("reset");
      rst = 1'b0;

      // Single request, served.
      cycle(4'b0001, 4'b0000, 0, 0, "t1a");
      cycle(4'b0000, 4'b0000, 0, 0, "t1b");
      check_eq("t1_snap", 8'(d_out), 8'h01);
      cycle(4'b0000, 4'b0000, 1, 0, "t1c");
      check_eq("t1_release", 8'(vld), 8'h00);

      // Two simultaneous requests, served highest first.
      cycle(4'b0011, 4'b0000, 0, 0, "t2a");
      cycle(4'b0011, 4'b0000, 0, 0, "t2b");
      check_eq("t2_snap", 8'(d_out), 8'h03);
      cycle(4'b0011, 4'b0000, 1, 0, "t2c");
      cycle(4'b0011, 4'b0000, 0, 0, "t2d");
      check_eq("t2_snap2", 8'(d_out), 8'h01);
      cycle(4'b0011, 4'b0000, 1, 0, "t2e");
      cycle(4'b0000, 4'b0000, 0, 0, "t2f");
      check_eq("t2_drained", 8'(vld), 8'h00);

      // Snapshot frozen while a higher request arrives.
      cycle(4'b0100, 4'b0000, 0, 0, "t3a");
      cycle(4'b0000, 4'b0000, 0, 0, "t3b");
      cycle(4'b1000, 4'b0000, 0, 0, "t3c");
      cycle(4'b1000, 4'b0000, 0, 0, "t3d");
      check_eq("t3_frozen", 8'(d_out), 8'h04);
      cycle(4'b1000, 4'b0000, 1, 0, "t3e");
      cycle(4'b1000, 4'b0000, 0, 0, "t3f");
      check_eq("t3_next", 8'(d_out), 8'h08);
      cycle(4'b0000, 4'b0000, 1, 0, "t3g");

      // Masked channel retained, presented once unmasked.
      cycle(4'b1100, 4'b1000, 0, 0, "t4a");
      cycle(4'b1100, 4'b1000, 0, 0, "t4b");
      check_eq("t4_masked", 8'(d_out), 8'h04);
      cycle(4'b1100, 4'b1000, 1, 0, "t4c");
      cycle(4'b1100, 4'b0000, 0, 0, "t4d");
      check_eq("t4_unmasked", 8'(d_out), 8'h08);
      cycle(4'b0000, 4'b0000, 1, 0, "t4e");

      // Wrong sel: error pulse and re-presentation.
      cycle(4'b0010, 4'b0000, 0, 0, "t5a");
      cycle(4'b0000, 4'b0000, 0, 0, "t5b");
      cycle(4'b0000, 4'b0000, 1, 1, "t5c");
      check_eq("t5_err", 8'(err), 8'h01);
      cycle(4'b0000, 4'b0000, 0, 0, "t5d");
      check_eq("t5_represent", 8'(d_out), 8'h02);
      check_eq("t5_err_once", 8'(err), 8'h00);
      cycle(4'b0000, 4'b0000, 1, 0, "t5e");

      // Asynchronous reset in HOLD, req held high across release.
      cycle(4'b0100, 4'b0000, 0, 0, "t6a");
      cycle(4'b0000, 4'b0000, 0, 0, "t6b");
      #2 rst = 1'b1;
      #1;
      check_eq("t6_async_vld", 8'(vld), 8'h00);
      check_eq("t6_async_dout", 8'(d_out), 8'h00);
      model_reset();
      req = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle(4'b1111, 4'b0000, 0, 0, "t6c");
      check_eq("t6_first_edge", 8'(vld), 8'h00);
      cycle(4'b1111, 4'b0000, 0, 0, "t6d");
      check_eq("t6_reassert", 8'(d_out), 8'h0f);

      // Random traffic.
      r = 4'b1111;
      m = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 4) == 0) r[i] = ~r[i];
         if ($urandom_range(0, 7) == 0) m = 4'($urandom_range(0, 15));
         cycle(r, m, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
